mc_pu_sched: RTL and testbench



---
 rtl/mc_pu_sched.sv | 209 ++++++++++++++++++++
 tb/tb_mc_pu_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_pu_sched.sv
// mc_pu_sched: memory-controller command sequencer with round-robin sharing
// of the operand buses across NUM_PU processing units.
// A job is one bulk load, then repeated transfer -> dispatch -> wait-for-PU
// rounds, one per operand pair.
// Optional build macro MC_SCHED_TIMEOUT_EN adds a per-state watchdog that
// cancels the job exactly like abort when a state stalls too long.
module mc_pu_sched #(
  parameter int NUM_PU  = 4,
  parameter int PTR_W   = 2,
  parameter int MAX_LEN = 31
`ifdef MC_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              mc_clk,
  input  logic              mc_reset,
  input  logic              start,
  input  logic [5:0]        length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [2:0]        mc_data_contition,
  output logic [5:0]        mc_data_length,
  input  logic              mc_done,
  output logic [NUM_PU-1:0] pu_valid,
  input  logic [NUM_PU-1:0] pu_ready,
  input  logic [NUM_PU-1:0] pu_done,
  output logic [PTR_W-1:0]  pu_sel
);

  typedef enum logic [2:0] {
    IDLE, LOAD, XFER, DISPATCH, WAIT_PU, FINISH
  } state_t;

  localparam logic [2:0] CmdIdle = 3'b000;
  localparam logic [2:0] CmdLoad = 3'b100;
  localparam logic [2:0] CmdXfer = 3'b010;
  localparam logic [2:0] CmdProc = 3'b001;
  localparam logic [5:0] MaxLen  = 6'(MAX_LEN);
  localparam logic [PTR_W-1:0] LastPtr = PTR_W'(NUM_PU - 1);

  state_t              state_q, state_d;
  logic [5:0]          len_q, len_d;
  logic [5:0]          pair_cnt_q, pair_cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                abort_flag_q, abort_flag_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [5:0]          mlen_q, mlen_d;
  logic [NUM_PU-1:0]   pu_valid_q, pu_valid_d;
  logic [PTR_W-1:0]    pu_sel_q, pu_sel_d;
  logic [5:0]          clamped;
  logic                active;
  logic                abort_evt;

  // Clamp the requested length to the RAM depth and flag the stallable states
  always_comb begin
    clamped = (length > MaxLen) ? MaxLen : length;
    active  = (state_q != IDLE) && (state_q != FINISH);
  end

`ifdef MC_SCHED_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;

  // Watchdog restarts on every state change and only runs while waiting on others
  always_comb begin
    wdog_d = 8'd0;
    if ((state_d == state_q) &&
        ((state_q == LOAD) || (state_q == XFER) || (state_q == WAIT_PU)))
      wdog_d = wdog_q + 8'd1;
    abort_evt = abort || (active && (wdog_q == 8'(TIMEOUT_CYCLES)));
  end

  // Watchdog register
  always_ff @(posedge mc_clk or posedge mc_reset) begin
    if (mc_reset) wdog_q <= 8'd0;
    else          wdog_q <= wdog_d;
  end
`else
  // Without the watchdog only an explicit abort cancels a job
  always_comb begin
    abort_evt = abort;
  end
`endif

  // Next-state and registered-output logic; abort outranks every other event
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    pair_cnt_d   = pair_cnt_q;
    ptr_d        = ptr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    abort_flag_d = abort_flag_q;
    cmd_d        = cmd_q;
    mlen_d       = mlen_q;
    pu_valid_d   = pu_valid_q;
    pu_sel_d     = pu_sel_q;
    if (active && abort_evt) begin
      cmd_d        = CmdIdle;
      pu_valid_d   = '0;
      abort_flag_d = 1'b1;
      state_d      = FINISH;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_d        = clamped;
            mlen_d       = clamped;
            busy_d       = 1'b1;
            pair_cnt_d   = 6'd0;
            abort_flag_d = 1'b0;
            if (clamped == 6'd0) begin
              state_d = FINISH;
            end else begin
              cmd_d   = CmdLoad;
              state_d = LOAD;
            end
          end
        end
        LOAD: begin
          if (mc_done) begin
            cmd_d   = CmdXfer;
            state_d = XFER;
          end
        end
        XFER: begin
          if (mc_done) begin
            pu_valid_d        = '0;
            pu_valid_d[ptr_q] = 1'b1;
            pu_sel_d          = ptr_q;
            state_d           = DISPATCH;
          end
        end
        DISPATCH: begin
          if (pu_ready[ptr_q]) begin
            pu_valid_d = '0;
            cmd_d      = CmdProc;
            pair_cnt_d = pair_cnt_q + 6'd1;
            state_d    = WAIT_PU;
          end
        end
        WAIT_PU: begin
          if (pu_done[ptr_q]) begin
            ptr_d = (ptr_q == LastPtr) ? '0 : ptr_q + PTR_W'(1);
            if (pair_cnt_q == len_q) begin
              cmd_d   = CmdIdle;
              state_d = FINISH;
            end else begin
              cmd_d   = CmdXfer;
              state_d = XFER;
            end
          end
        end
        FINISH: begin
          done_d    = 1'b1;
          aborted_d = abort_flag_q;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset drops everything back to idle at once
  always_ff @(posedge mc_clk or posedge mc_reset) begin
    if (mc_reset) begin
      state_q      <= IDLE;
      len_q        <= 6'd0;
      pair_cnt_q   <= 6'd0;
      ptr_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_flag_q <= 1'b0;
      cmd_q        <= CmdIdle;
      mlen_q       <= 6'd0;
      pu_valid_q   <= '0;
      pu_sel_q     <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      pair_cnt_q   <= pair_cnt_d;
      ptr_q        <= ptr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_flag_q <= abort_flag_d;
      cmd_q        <= cmd_d;
      mlen_q       <= mlen_d;
      pu_valid_q   <= pu_valid_d;
      pu_sel_q     <= pu_sel_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign aborted           = aborted_q;
  assign mc_data_contition = cmd_q;
  assign mc_data_length    = mlen_q;
  assign pu_valid          = pu_valid_q;
  assign pu_sel            = pu_sel_q;

endmodule

// File: tb/tb_mc_pu_sched.sv
// Testbench for mc_pu_sched: directed jobs, expected command / offer / done
// events queued by the stimulus and checked by an independent monitor.
module tb_mc_pu_sched;

  logic       mc_clk;
  logic       mc_reset;
  logic       start;
  logic [5:0] length;
  logic       abort;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [2:0] mc_data_contition;
  logic [5:0] mc_data_length;
  logic       mc_done;
  logic [3:0] pu_valid;
  logic [3:0] pu_ready;
  logic [3:0] pu_done;
  logic [1:0] pu_sel;

  int checkCount = 0;
  int failCount  = 0;
  logic [15:0] expQ[$];
  int modelPtr = 0;

  bit memEnable = 1'b1;
  int abortReqNum = 0;
  int abortArmNum = 0;

  mc_pu_sched dut (
    .mc_clk(mc_clk),
    .mc_reset(mc_reset),
    .start(start),
    .length(length),
    .abort(abort),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .mc_data_contition(mc_data_contition),
    .mc_data_length(mc_data_length),
    .mc_done(mc_done),
    .pu_valid(pu_valid),
    .pu_ready(pu_ready),
    .pu_done(pu_done),
    .pu_sel(pu_sel)
  );

  initial mc_clk = 1'b0;
  always #5 mc_clk = ~mc_clk;

  initial begin
    #300000;
    $display("[TB] FAIL global-timeout: simulation limit reached, required finish");
    $fatal(1, "[TB] stopped");
  end

  function automatic logic [15:0] tokCmd(input logic [2:0] c);
    return {4'd1, 9'd0, c};
  endfunction

  function automatic logic [15:0] tokOffer(input int p);
    logic [3:0] oh;
    oh = 4'b0001 << p;
    return {4'd2, 6'd0, 2'(p), oh};
  endfunction

  function automatic logic [15:0] tokDone(input logic ab);
    return {4'd3, 10'd0, ab, 1'b0};
  endfunction

  // Expected event stream for a job; abortFirst cancels in the first WAIT_PU
  task automatic expectJob(input int len, input bit abortFirst);
    int n;
    n = (len > 31) ? 31 : len;
    if (n > 0) begin
      expQ.push_back(tokCmd(3'b100));
      expQ.push_back(tokCmd(3'b010));
      for (int i = 0; i < n; i++) begin
        expQ.push_back(tokOffer(modelPtr));
        expQ.push_back(tokCmd(3'b001));
        if (abortFirst) begin
          expQ.push_back(tokCmd(3'b000));
          break;
        end
        modelPtr = (modelPtr + 1) % 4;
        expQ.push_back(tokCmd((i == n - 1) ? 3'b000 : 3'b010));
      end
    end
    expQ.push_back(tokDone(abortFirst));
  endtask

  task automatic observe(input string name, input logic [15:0] act);
    logic [15:0] exp;
    checkCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL %s: unexpected event got %h, required none", name, act);
    end else begin
      exp = expQ.pop_front();
      if (act !== exp) begin
        failCount++;
        $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and scores them
  initial begin
    logic [2:0] prevCmd;
    logic [3:0] prevValid;
    prevCmd = 3'b000;
    prevValid = 4'b0000;
    forever begin
      @(negedge mc_clk);
      if (!mc_reset) begin
        if (mc_data_contition !== prevCmd)
          observe("cmd", tokCmd(mc_data_contition));
        if (pu_valid !== 4'b0000 && prevValid === 4'b0000)
          observe("offer", {4'd2, 6'd0, pu_sel, pu_valid});
        if (done === 1'b1)
          observe("done", {4'd3, 10'd0, aborted, busy});
      end
      prevCmd = mc_reset ? 3'b000 : mc_data_contition;
      prevValid = mc_reset ? 4'b0000 : pu_valid;
    end
  end

  // Memory controller model: step complete two cycles after each load/transfer
  initial begin
    logic [2:0] prevCmd;
    int memCnt;
    prevCmd = 3'b000;
    memCnt = 0;
    mc_done = 1'b0;
    forever begin
      @(negedge mc_clk);
      mc_done = 1'b0;
      if (memCnt > 0) begin
        memCnt--;
        if (memCnt == 0) mc_done = memEnable;
      end
      if (mc_data_contition != prevCmd &&
          (mc_data_contition == 3'b100 || mc_data_contition == 3'b010))
        memCnt = 1;
      prevCmd = mc_data_contition;
    end
  end

  // PU array model: immediate accept and completion, plus abort injection
  initial begin
    int reqSeen;
    int armSeen;
    reqSeen = 0;
    armSeen = 0;
    pu_ready = 4'b0000;
    pu_done = 4'b0000;
    abort = 1'b0;
    forever begin
      @(negedge mc_clk);
      pu_ready = pu_valid;
      pu_done = (mc_data_contition == 3'b001) ? (4'b0001 << pu_sel) : 4'b0000;
      abort = 1'b0;
      if (armSeen != abortArmNum && mc_data_contition == 3'b001) begin
        abort = 1'b1;
        armSeen = abortArmNum;
      end
      if (reqSeen != abortReqNum) begin
        abort = 1'b1;
        reqSeen = abortReqNum;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int len);
    @(negedge mc_clk);
    start = 1'b1;
    length = 6'(len);
    @(negedge mc_clk);
    start = 1'b0;
    length = 6'd0;
  endtask

  task automatic applyReset();
    @(negedge mc_clk);
    mc_reset = 1'b1;
    modelPtr = 0;
    repeat (3) @(negedge mc_clk);
    checkOutput("reset busy", 8'(busy), 8'd0);
    checkOutput("reset done", 8'(done), 8'd0);
    checkOutput("reset cmd", 8'(mc_data_contition), 8'd0);
    checkOutput("reset mlen", 8'(mc_data_length), 8'd0);
    checkOutput("reset pu_valid", 8'(pu_valid), 8'd0);
    checkOutput("reset pu_sel", 8'(pu_sel), 8'd0);
    mc_reset = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int maxCycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge mc_clk);
      if (expQ.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    checkCount++;
    if (!ok) begin
      failCount++;
      $display("[TB] FAIL %s: job not complete, %0d events pending, busy=%0d, required 0 pending and idle",
               name, expQ.size(), busy);
      expQ.delete();
    end
  endtask

  initial begin
    mc_reset = 1'b1;
    start = 1'b0;
    length = 6'd0;
    applyReset();

    $display("[TB] job of 3 pairs");
    expectJob(3, 1'b0);
    applyStimulus(3);
    checkOutput("len3 mlen", 8'(mc_data_length), 8'd3);
    checkOutput("len3 busy", 8'(busy), 8'd1);
    repeat (4) @(negedge mc_clk);
    start = 1'b1;
    length = 6'd5;
    @(negedge mc_clk);
    start = 1'b0;
    length = 6'd0;
    checkOutput("start while busy mlen", 8'(mc_data_length), 8'd3);
    waitIdle("len3 job", 200);

    $display("[TB] back-to-back job, pointer retained");
    expectJob(3, 1'b0);
    applyStimulus(3);
    waitIdle("len3 second job", 200);

    applyReset();

    $display("[TB] clamped job of 40");
    expectJob(40, 1'b0);
    applyStimulus(40);
    checkOutput("len40 mlen", 8'(mc_data_length), 8'd31);
    waitIdle("len40 job", 1000);

    $display("[TB] empty job");
    expectJob(0, 1'b0);
    applyStimulus(0);
    checkOutput("len0 done early", 8'(done), 8'd0);
    @(negedge mc_clk);
    checkOutput("len0 done", 8'(done), 8'd1);
    checkOutput("len0 aborted", 8'(aborted), 8'd0);
    waitIdle("len0 job", 20);

    $display("[TB] abort with pu_done in WAIT_PU");
    expectJob(3, 1'b1);
    abortArmNum++;
    applyStimulus(3);
    waitIdle("abort job", 200);

    $display("[TB] follow-up job after abort");
    expectJob(2, 1'b0);
    applyStimulus(2);
    waitIdle("post-abort job", 200);

    $display("[TB] stalled memory controller");
    memEnable = 1'b0;
`ifdef MC_SCHED_TIMEOUT_EN
    expQ.push_back(tokCmd(3'b100));
    expQ.push_back(tokCmd(3'b000));
    expQ.push_back(tokDone(1'b1));
    applyStimulus(2);
    waitIdle("watchdog job", 400);
`else
    expQ.push_back(tokCmd(3'b100));
    applyStimulus(2);
    repeat (1000) @(negedge mc_clk);
    checkOutput("stall busy", 8'(busy), 8'd1);
    checkOutput("stall cmd", 8'(mc_data_contition), 8'd4);
    expQ.push_back(tokCmd(3'b000));
    expQ.push_back(tokDone(1'b1));
    abortReqNum++;
    waitIdle("stall abort", 50);
`endif
    memEnable = 1'b1;
    repeat (3) @(negedge mc_clk);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
